// File: rtl/rat_pkg.sv
// Shared definitions for the rat sprite path.
// Contents:
//   loader_state_t - sprite_loader FSM states
//   SPRITE_DIM     - sprite edge length in pixels
//   FRAME_PIX      - pixels per animation frame
//   PIX_PER_BYTE   - palette codes packed into one streamed byte
package rat_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCsum,
      StFin
   } loader_state_t;

   localparam int unsigned SPRITE_DIM   = 16;
   localparam int unsigned FRAME_PIX    = SPRITE_DIM * SPRITE_DIM;
   localparam int unsigned PIX_PER_BYTE = 2;

endpackage

// File: rtl/sprite_loader.sv
// sprite_loader: streams packed 4-bit palette codes into the sprite RAM write port.
// Each accepted byte produces two consecutive writes (low nibble first). One 16x16
// frame or the whole RAM is loaded per start.
// Optional feature macro: SPRITE_LOADER_CSUM_EN (adds an XOR trailer byte check).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   start                 - begin a load (sampled in IDLE only)
//   all_frames, frame_sel - load scope, captured at start
//   s_data/s_valid/s_ready - byte stream handshake
//   we/addr_w/pixel_in    - sprite RAM write port
//   busy, done, err       - status (done is a one-cycle pulse, err is sticky)
module sprite_loader
   import rat_pkg::*;
#(
   parameter int unsigned ADDR = 10,
   parameter int unsigned PW   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            all_frames,
   input  logic [ADDR-9:0] frame_sel,
   input  logic [7:0]      s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic            we,
   output logic [ADDR-1:0] addr_w,
   output logic [PW-1:0]   pixel_in,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [ADDR-1:0] AllBytes   = ADDR'((2 ** ADDR) / PIX_PER_BYTE);
   localparam logic [ADDR-1:0] FrameBytes = ADDR'(FRAME_PIX / PIX_PER_BYTE);

   loader_state_t   state_q, state_d;
   logic            phase_q, phase_d;   // high nibble pending
   logic [PW-1:0]   hold_q, hold_d;
   logic [ADDR-1:0] ptr_q, ptr_d;       // next write address
   logic [ADDR-1:0] bytes_q, bytes_d;   // data bytes still to accept
   logic            we_q, we_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [PW-1:0]   pix_q, pix_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
`ifdef SPRITE_LOADER_CSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic accept;
   assign accept = s_valid & ready_q;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         phase_q <= 1'b0;
         hold_q  <= '0;
         ptr_q   <= '0;
         bytes_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         pix_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef SPRITE_LOADER_CSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
         bytes_q <= bytes_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef SPRITE_LOADER_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StLoad;
         StLoad: begin
            // Last high-nibble write has been issued once nothing is pending.
            if (!phase_q && !accept && bytes_q == '0) begin
`ifdef SPRITE_LOADER_CSUM_EN
               state_d = StCsum;
`else
               state_d = StFin;
`endif
            end
         end
         StCsum: if (accept) state_d = StFin;
         StFin:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath and next output values
   always_comb begin
      phase_d = phase_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      bytes_d = bytes_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      pix_d   = pix_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
`ifdef SPRITE_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ptr_d   = all_frames ? '0 : {frame_sel, 8'h00};
               bytes_d = all_frames ? AllBytes : FrameBytes;
               phase_d = 1'b0;
               ready_d = 1'b1;
               busy_d  = 1'b1;
               err_d   = 1'b0;
`ifdef SPRITE_LOADER_CSUM_EN
               csum_d  = '0;
`endif
            end
         end
         StLoad: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               pix_d   = s_data[PW-1:0];
               hold_d  = s_data[2*PW-1:PW];
               ptr_d   = ptr_q + 1'b1;
               bytes_d = bytes_q - 1'b1;
               phase_d = 1'b1;
               ready_d = 1'b0;
`ifdef SPRITE_LOADER_CSUM_EN
               csum_d  = csum_q ^ s_data;
`endif
            end else if (phase_q) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               pix_d   = hold_q;
               ptr_d   = ptr_q + 1'b1;
               phase_d = 1'b0;
               ready_d = (bytes_q != '0);
            end else if (bytes_q == '0) begin
`ifdef SPRITE_LOADER_CSUM_EN
               ready_d = 1'b1;
`else
               done_d  = 1'b1;
               busy_d  = 1'b0;
`endif
            end
         end
         StCsum: begin
`ifdef SPRITE_LOADER_CSUM_EN
            if (accept) begin
               ready_d = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               err_d   = (s_data != csum_q);
            end
`endif
         end
         StFin: begin
            ready_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign we       = we_q;
   assign addr_w   = addr_q;
   assign pixel_in = pix_q;
   assign s_ready  = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Directed self-checking bench for sprite_loader.
module tb_sprite_loader;

   localparam int unsigned ADDR = 10;
   localparam int unsigned PW   = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            all_frames = 1'b0;
   logic [1:0]      frame_sel = '0;
   logic [7:0]      s_data = '0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic            we;
   logic [ADDR-1:0] addr_w;
   logic [PW-1:0]   pixel_in;
   logic            busy;
   logic            done;
   logic            err;

   sprite_loader #(.ADDR(ADDR), .PW(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .all_frames (all_frames),
      .frame_sel  (frame_sel),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .we         (we),
      .addr_w     (addr_w),
      .pixel_in   (pixel_in),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Write log captured from the RAM port
   logic [3:0] mem     [1024];
   logic [3:0] exp_mem [1024];
   int         log_addr[4096];
   int         total_wr = 0;

   always @(negedge clk) begin
      if (we) begin
         if (total_wr < 4096) log_addr[total_wr] <= int'(addr_w);
         mem[addr_w] <= pixel_in;
         total_wr    <= total_wr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int kind, input int i);
      case (kind)
         0:       return 8'(i) ^ 8'hA5;
         1:       return 8'h21;
         2:       return 8'(i << 4);   // low nibble is always the chroma key
         default: return 8'(i * 7) ^ 8'(i >> 3);
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},     32'(we),       32'd0);
      check({tag, "_addr"},   32'(addr_w),   32'd0);
      check({tag, "_pixel"},  32'(pixel_in), 32'd0);
      check({tag, "_ready"},  32'(s_ready),  32'd0);
      check({tag, "_busy"},   32'(busy),     32'd0);
      check({tag, "_done"},   32'(done),     32'd0);
      check({tag, "_err"},    32'(err),      32'd0);
   endtask

   // Called just after a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 64) check("ready_timeout", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic run_load(input logic all, input logic [1:0] sel, input int kind,
                           input bit stalls, input bit poke_start, input bit bad_trailer);
      int         base;
      int         nbytes;
      int         first_wr;
      int         bad;
      int         stall;
      logic [7:0] b;
      logic [7:0] csum;
      base   = all ? 0 : int'(sel) * 256;
      nbytes = all ? 512 : 128;
      csum   = '0;
      b      = '0;
      all_frames = all;
      frame_sel  = sel;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy",  32'(busy),    32'd1);
      check("start_ready", 32'(s_ready), 32'd1);
      check("start_err",   32'(err),     32'd0);
      first_wr = total_wr;
      for (int i = 0; i < nbytes; i++) begin
         b = pat(kind, i);
         exp_mem[base + 2 * i]     = b[3:0];
         exp_mem[base + 2 * i + 1] = b[7:4];
         csum = csum ^ b;
         send_byte(b);
         if (i == 0) begin
            check("first_we",   32'(we),     32'd1);
            check("first_addr", 32'(addr_w), 32'(base));
         end
         if (poke_start && i == 10) begin
            frame_sel  = 2'd3;
            all_frames = 1'b0;
            start      = 1'b1;
            @(negedge clk);
            start     = 1'b0;
            frame_sel = sel;
         end
         if (stalls && i != nbytes - 1) begin
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
               @(negedge clk);
               if (k == 1) check("stall_we", 32'(we), 32'd0);
            end
         end
      end
`ifdef SPRITE_LOADER_CSUM_EN
      send_byte(bad_trailer ? (csum ^ 8'h01) : csum);
      check("csum_done", 32'(done), 32'd1);
      check("csum_busy", 32'(busy), 32'd0);
      check("csum_err",  32'(err),  32'(bad_trailer));
      @(negedge clk);
      check("csum_done_low", 32'(done), 32'd0);
`else
      // Last byte: writes at T+1, T+2, done at T+3
      check("last_lo_we",   32'(we),       32'd1);
      check("last_lo_addr", 32'(addr_w),   32'(base + 2 * nbytes - 2));
      check("last_lo_pix",  32'(pixel_in), 32'(b[3:0]));
      check("last_lo_rdy",  32'(s_ready),  32'd0);
      @(negedge clk);
      check("last_hi_we",   32'(we),       32'd1);
      check("last_hi_addr", 32'(addr_w),   32'(base + 2 * nbytes - 1));
      check("last_hi_pix",  32'(pixel_in), 32'(b[7:4]));
      check("last_hi_busy", 32'(busy),     32'd1);
      check("last_hi_done", 32'(done),     32'd0);
      @(negedge clk);
      check("fin_done", 32'(done), 32'd1);
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_we",   32'(we),   32'd0);
      check("fin_err",  32'(err),  32'd0);
      @(negedge clk);
      check("fin_done_low", 32'(done), 32'd0);
      if (bad_trailer) check("unused_trailer_err", 32'(err), 32'd0);
`endif
      check("wr_count", 32'(total_wr - first_wr), 32'(2 * nbytes));
      bad = 0;
      for (int k = 0; k < 2 * nbytes; k++) begin
         if (log_addr[first_wr + k] != base + k) bad++;
      end
      check("wr_order", 32'(bad), 32'd0);
      bad = 0;
      for (int a = base; a < base + 2 * nbytes; a++) begin
         if (mem[a] !== exp_mem[a]) bad++;
      end
      check("mem_data", 32'(bad), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a load
      all_frames = 1'b0;
      frame_sel  = 2'd0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h5A);
      send_byte(8'hC3);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      @(negedge clk);

      // Normal frame 0, then back-to-back frame 2 of 0x21
      run_load(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0);
      run_load(1'b0, 2'd2, 1, 1'b0, 1'b0, 1'b0);

      // Start pulsed mid-load must be ignored
      @(negedge clk);
      run_load(1'b0, 2'd1, 2, 1'b0, 1'b1, 1'b0);

      // Whole RAM with random stalls
      @(negedge clk);
      run_load(1'b1, 2'd0, 3, 1'b1, 1'b0, 1'b0);

`ifdef SPRITE_LOADER_CSUM_EN
      @(negedge clk);
      run_load(1'b0, 2'd3, 0, 1'b0, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
      run_load(1'b0, 2'd3, 3, 1'b0, 1'b0, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_we",   32'(we),   32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
